// File: rtl/thermo_pkg.sv
// Shared types, default sizing and helper function for the thermometer expander.
package thermo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int T_WIDTH = 255;
  localparam int T_CW    = 8;
  localparam int T_CHUNK = 16;

  // Integer ceiling division, used to size the FILL sweep.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/thermo_chunk.sv
// Combinational mask for one chunk of the thermometer word:
// bit k is set when position base+k lies below both cnt and WIDTH.
module thermo_chunk
  import thermo_pkg::*;
#(
  parameter int WIDTH = T_WIDTH,
  parameter int CW    = T_CW,
  parameter int CHUNK = T_CHUNK,
  parameter int IW    = $clog2(T_WIDTH + T_CHUNK)
) (
  input  logic [IW-1:0]    i_base,
  input  logic [CW-1:0]    i_cnt,
  output logic [CHUNK-1:0] o_mask
);

  logic [IW-1:0] w_pos;

  // Compare every position of the chunk at the index width, cnt zero-extended.
  always_comb begin
    o_mask = '0;
    w_pos  = '0;
    for (int k = 0; k < CHUNK; k++) begin
      w_pos     = i_base + IW'(k);
      o_mask[k] = (w_pos < IW'(i_cnt)) && (w_pos < IW'(WIDTH));
    end
  end

endmodule

// File: rtl/thermo_gen.sv
// Count-to-thermometer expander: accepts N, writes bits [N-1:0] of a
// WIDTH-bit word CHUNK bits per cycle, then holds it on a valid/ready port.
module thermo_gen
  import thermo_pkg::*;
#(
  parameter int WIDTH = T_WIDTH,
  parameter int CW    = T_CW,
  parameter int CHUNK = T_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_sat
);

  // idx steps past WIDTH on the last chunk, so it is sized to never wrap.
  localparam int IW  = $clog2(WIDTH + CHUNK);
  localparam int NCH = ceil_div(WIDTH, CHUNK);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic             r_sat;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;

  logic [CHUNK-1:0] w_mask;
  logic [WIDTH-1:0] w_out_fill;
  logic             w_last;
  logic             w_accept;
  logic             w_over;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_over   = (int'(in_count) > WIDTH);
  assign w_last   = (r_idx + IW'(CHUNK)) >= IW'(WIDTH);

  thermo_chunk #(
    .WIDTH (WIDTH),
    .CW    (CW),
    .CHUNK (CHUNK),
    .IW    (IW)
  ) u_chunk (
    .i_base (r_idx),
    .i_cnt  (r_cnt),
    .o_mask (w_mask)
  );

  // Merge the current chunk mask into the word; idx is always a chunk multiple,
  // and positions at or above WIDTH do not exist in the word.
  always_comb begin
    w_out_fill = r_out;
    for (int j = 0; j < WIDTH; j++) begin
      if (r_idx == IW'((j / CHUNK) * CHUNK)) begin
        w_out_fill[j] = w_mask[j % CHUNK];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode: accept in IDLE, sweep NCH chunks in FILL, wait in HOLD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = FILL;
      FILL:    if (w_last)    w_state_nxt = HOLD;
      HOLD:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch clamped count on acceptance, fill one chunk per cycle,
  // raise valid with the last chunk and drop it on the output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= w_over ? CW'(WIDTH) : in_count;
      r_sat <= w_over;
      r_out <= '0;
      r_idx <= '0;
    end else if (r_state == FILL) begin
      r_out <= w_out_fill;
      r_idx <= r_idx + IW'(CHUNK);
      if (w_last) r_out_valid <= 1'b1;
    end else if ((r_state == HOLD) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_sat   = r_sat;

endmodule
